// File: rtl/wb_mem_slave_if.sv
// Wishbone B4 pipelined bus bundle for wb_mem_slave.
// wb_err_o exists only when WB_MEM_ERR_EN is defined.
interface wb_mem_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;
`ifdef WB_MEM_ERR_EN
  logic        wb_err_o;
`endif

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
`ifdef WB_MEM_ERR_EN
    , output wb_err_o
`endif
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
`ifdef WB_MEM_ERR_EN
    , input wb_err_o
`endif
  );
endinterface

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 slave memory with fixed response latency and
// outstanding-request back-pressure. Boot/program memory for the fetch path.
// Optional feature macro WB_MEM_ERR_EN: out-of-range addresses get an error
// response and their writes are dropped; without it, addresses alias.
module wb_mem_slave #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_mem_slave_if.slave wb
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic [LATENCY-1:0] vld_q;
  logic [31:0]        dat_q [LATENCY];
  logic [2:0]         cnt_q;
  logic [AW-1:0]      widx;
  logic [31:0]        rd_dat;
  logic               accept;
  logic               resp;
  logic               ack;
  logic               stall;
  logic               oor;
  logic               unused_adr;

  assign widx = wb.wb_adr_i[AW+1:2];

`ifdef WB_MEM_ERR_EN
  logic [LATENCY-1:0] err_q;

  assign oor        = |wb.wb_adr_i[31:AW+2];
  assign unused_adr = ^wb.wb_adr_i[1:0];
  assign ack        = resp & ~err_q[LATENCY-1];
  assign wb.wb_err_o = resp & err_q[LATENCY-1];
`else
  assign oor        = 1'b0;
  assign unused_adr = ^{wb.wb_adr_i[31:AW+2], wb.wb_adr_i[1:0]};
  assign ack        = resp;
`endif

  // An err response frees a slot exactly like an ack, so both count as resp.
  assign resp   = wb.wb_cyc_i & vld_q[LATENCY-1];
  assign stall  = (cnt_q == 3'(MAX_OUTSTANDING)) & ~resp;
  assign accept = wb.wb_cyc_i & wb.wb_stb_i & ~stall;
  assign rd_dat = (accept & ~wb.wb_we_i & ~oor) ? mem_q[widx] : '0;

  assign wb.wb_ack_o   = ack;
  assign wb.wb_stall_o = stall;
  assign wb.wb_dat_o   = ack ? dat_q[LATENCY-1] : '0;

  // Byte-enabled write commit at the acceptance edge; array is never reset.
  always_ff @(posedge clk_i) begin
    if (accept && wb.wb_we_i && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.wb_sel_i[b]) mem_q[widx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  // Response pipeline; dropping cyc flushes every in-flight valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
`ifdef WB_MEM_ERR_EN
      err_q <= '0;
`endif
    end else begin
      vld_q[0] <= accept;
      dat_q[0] <= rd_dat;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1] & wb.wb_cyc_i;
        dat_q[i] <= dat_q[i-1];
      end
`ifdef WB_MEM_ERR_EN
      err_q[0] <= accept & oor;
      for (int i = 1; i < LATENCY; i++) err_q[i] <= err_q[i-1];
`endif
    end
  end

  // Outstanding-request counter; abort wins over accept and response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (!wb.wb_cyc_i) begin
      cnt_q <= '0;
    end else begin
      case ({accept, resp})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Pipelined Wishbone B4 slave memory that answers instruction fetches from `ifm` and, in later integrations, data accesses from the load/store unit. It accepts one request per cycle and returns each response after a fixed, configurable latency. It applies `wb_stall_o` back-pressure when the number of outstanding requests reaches a limit. It serves as the on-chip boot/program memory and as the bench-side responder for fetch-path verification.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 2: cycles from request acceptance to `wb_ack_o`; legal range 1..4.
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unacknowledged requests; legal range 1..4.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `wb_adr_i` input 32: byte address; the word index is `wb_adr_i[log2(DEPTH_WORDS)+1:2]`, and `[1:0]` is ignored.
- `wb_dat_i` input 32: write data.
- `wb_sel_i` input 4: byte enables for writes; bit n enables byte n.
- `wb_we_i` input 1: 1 = write, 0 = read.
- `wb_stb_i` input 1: request strobe.
- `wb_cyc_i` input 1: bus cycle active.
- `wb_dat_o` output 32: read data, valid while `wb_ack_o` = 1.
- `wb_ack_o` output 1: response strobe, one cycle per accepted request.
- `wb_stall_o` output 1: request not accepted this cycle.
- `wb_err_o` output 1: error response; present only with `WB_MEM_ERR_EN`.

## Operation
- A request is accepted at a rising edge where `wb_cyc_i & wb_stb_i & !wb_stall_o`.
- Writes commit to the array at the acceptance edge, per `wb_sel_i`. Unselected bytes are unchanged.
- Reads sample the array at the acceptance edge. A read accepted one edge after a write to the same word returns the new data.
- The response pipeline has `LATENCY` stages. Each stage holds valid, data, and (with the macro) an err flag.
- Stage 0 is loaded at acceptance. The last stage drives `wb_ack_o`/`wb_dat_o`.
- Write responses return `wb_dat_o` = 0.
- The outstanding counter `cnt_q` (width 3):
  - +1 on acceptance.
  - −1 on an edge where `wb_ack_o` = 1.
  - Both at once: unchanged.
- `wb_stall_o` = (`cnt_q` == `MAX_OUTSTANDING`) & !`wb_ack_o`. This is combinational, so a slot freed by the current ack is reusable in the same cycle.
- Sustained one-per-cycle throughput requires `MAX_OUTSTANDING` ≥ `LATENCY`.
- Bus abort: when `wb_cyc_i` = 0 at an edge, all pipeline valids and `cnt_q` clear to 0.
  - `wb_ack_o` is gated combinationally by `wb_cyc_i`, so no ack is visible while cyc is low.
  - Writes already committed stay committed.
- `wb_stb_i` without `wb_cyc_i` is ignored.
- Array contents are not reset. Simulation may preload via `$readmemh` from the bench.

## Timing
- Reset (`rst_i` = 0, asynchronous): `wb_ack_o` = 0, `wb_dat_o` = 0, `wb_stall_o` = 0, `wb_err_o` = 0, `cnt_q` = 0, all stage valids = 0.
- Reset asserted mid-transfer discards all in-flight responses. The first acceptance is possible on the first rising edge after deassertion.
- Request accepted at edge e0 → `wb_ack_o` high for exactly one cycle, between edges e(LATENCY−1) and e(LATENCY).
- Response order equals acceptance order. There is no reordering and no ack merging.
- Acceptance, ack, and abort may coincide. Abort takes precedence: the counter becomes 0, and the request accepted at that edge is also discarded because `wb_cyc_i` = 0 blocks acceptance.

## Configuration
- `WB_MEM_ERR_EN` defined:
  - Adds `wb_err_o`.
  - An address with any bit set in `wb_adr_i[31:log2(DEPTH_WORDS)+2]` is out of range.
  - Out-of-range requests are still accepted and counted.
  - Writes are suppressed.
  - The response has `wb_err_o` = 1, `wb_ack_o` = 0, `wb_dat_o` = 0, at the same latency as a normal response.
  - The counter decrements on err exactly as on ack.
  - `wb_err_o` is gated by `wb_cyc_i`.
- `WB_MEM_ERR_EN` undefined:
  - There is no `wb_err_o` port.
  - Upper address bits are ignored, so accesses alias modulo `DEPTH_WORDS`.

## Test plan
- Reset: hold `rst_i` = 0 with random bus inputs → `wb_ack_o` = 0, `wb_stall_o` = 0, `wb_dat_o` = 0 throughout. Deassert and read 0x0 → ack arrives exactly `LATENCY` edges later.
- Latency (LATENCY = 2): preload word 3 = 0xDEADBEEF, read 0x0000000C at edge e0 → ack with 0xDEADBEEF only in the cycle between e1 and e2.
- Throughput (LATENCY = 2, MAX_OUTSTANDING = 2): 8 back-to-back reads at 0x0, 0x4 … 0x1C → no stall, 8 consecutive acks, data in order.
- Back-pressure (LATENCY = 3, MAX_OUTSTANDING = 1): continuous strobe → stall high two of every three cycles, one accept per 3 cycles, no lost or duplicated acks.
- Byte write: write 0x11223344 with sel = 4'b0101 to a word holding 0xAABBCCDD, then read it on the next cycle → 0xAA22CC44.
- Abort: accept 2 reads, drop `wb_cyc_i` before the first ack → no ack ever appears, `cnt_q` = 0, and the next cycle's request is serviced normally. With `WB_MEM_ERR_EN` and DEPTH_WORDS = 1024, reading 0x00001000 → `wb_err_o` pulse, no ack, array unchanged.
